ycr_dmem_wb_initiator: RTL and testbench

//  Wishbone-classic slave to YCR dmem-protocol initiator bridge. It lets an external bus master
//  (host loader, debug/DMA port) read and write the TCM over the same dmem request/ack/resp

---
 rtl/ycr_dmem_wb_initiator_pkg.sv | 42 ++++
 rtl/ycr_dmem_wb_initiator_if.sv | 27 ++
 rtl/ycr_wbi_sel_decode.sv | 31 +++
 rtl/ycr_dmem_wb_initiator.sv | 143 ++++++++++++++
 tb/tb_ycr_dmem_wb_initiator.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ycr_dmem_wb_initiator_pkg.sv
// Shared types for the Wishbone-to-dmem initiator bridge.
// Holds the YCR dmem protocol encodings (command, width, response), the bridge FSM state type
// and a helper that expands a Wishbone byte select into a 32-bit lane mask.
package ycr_dmem_wb_initiator_pkg;

  typedef enum logic {
    YCR_MEM_CMD_RD = 1'b0,
    YCR_MEM_CMD_WR = 1'b1
  } type_ycr_mem_cmd_e;

  typedef enum logic [1:0] {
    YCR_MEM_WIDTH_BYTE  = 2'b00,
    YCR_MEM_WIDTH_HWORD = 2'b01,
    YCR_MEM_WIDTH_WORD  = 2'b10
  } type_ycr_mem_width_e;

  typedef enum logic [1:0] {
    YCR_MEM_RESP_NOTRDY = 2'b00,
    YCR_MEM_RESP_RDY_OK = 2'b01,
    YCR_MEM_RESP_RDY_ER = 2'b10
  } type_ycr_mem_resp_e;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StResp,
    StAck,
    StErr,
    StDone
  } type_ycr_wbi_fsm_e;

  // Byte-lane select -> bit mask (one byte of ones per selected lane).
  function automatic logic [31:0] ycr_wbi_sel_mask(input logic [3:0] sel);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ycr_dmem_wb_initiator_if.sv
// Wishbone-classic bus bundle seen by the dmem initiator bridge.
// Signal names are from the bridge's point of view (_i = into the bridge).
//   slave  : the bridge (samples cyc/stb/we/adr/dat/sel, returns dat_o/ack/err)
//   master : the external bus master (host loader, debug/DMA port)
interface ycr_dmem_wb_initiator_if;

  logic        wbd_cyc_i;
  logic        wbd_stb_i;
  logic        wbd_we_i;
  logic [31:0] wbd_adr_i;
  logic [31:0] wbd_dat_i;
  logic [3:0]  wbd_sel_i;
  logic [31:0] wbd_dat_o;
  logic        wbd_ack_o;
  logic        wbd_err_o;

  modport slave (
    input  wbd_cyc_i, wbd_stb_i, wbd_we_i, wbd_adr_i, wbd_dat_i, wbd_sel_i,
    output wbd_dat_o, wbd_ack_o, wbd_err_o
  );

  modport master (
    output wbd_cyc_i, wbd_stb_i, wbd_we_i, wbd_adr_i, wbd_dat_i, wbd_sel_i,
    input  wbd_dat_o, wbd_ack_o, wbd_err_o
  );

endinterface

// File: rtl/ycr_wbi_sel_decode.sv
// Combinational decode of a Wishbone byte select into a dmem access.
//   sel_i     : byte lane select
//   width_o   : dmem access width
//   lane_o    : byte offset of the access within the word
//   illegal_o : select pattern has no single naturally-aligned dmem equivalent
module ycr_wbi_sel_decode
  import ycr_dmem_wb_initiator_pkg::*;
(
  input  logic [3:0]          sel_i,
  output type_ycr_mem_width_e width_o,
  output logic [1:0]          lane_o,
  output logic                illegal_o
);

  always_comb begin
    width_o   = YCR_MEM_WIDTH_WORD;
    lane_o    = 2'd0;
    illegal_o = 1'b0;
    case (sel_i)
      4'b0001: begin width_o = YCR_MEM_WIDTH_BYTE;  lane_o = 2'd0; end
      4'b0010: begin width_o = YCR_MEM_WIDTH_BYTE;  lane_o = 2'd1; end
      4'b0100: begin width_o = YCR_MEM_WIDTH_BYTE;  lane_o = 2'd2; end
      4'b1000: begin width_o = YCR_MEM_WIDTH_BYTE;  lane_o = 2'd3; end
      4'b0011: begin width_o = YCR_MEM_WIDTH_HWORD; lane_o = 2'd0; end
      4'b1100: begin width_o = YCR_MEM_WIDTH_HWORD; lane_o = 2'd2; end
      4'b1111: begin width_o = YCR_MEM_WIDTH_WORD;  lane_o = 2'd0; end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ycr_dmem_wb_initiator.sv
// Wishbone-classic slave to YCR dmem initiator bridge.
// Lets an external bus master read/write the TCM through the core's dmem req/ack/resp
// protocol, one transaction at a time. A responder that never answers is cut off after
// RESP_TMO cycles in RESP (0 disables) and reported as a bus error.
//   clk, rst_n     : clock, asynchronous active-low reset
//   wb             : Wishbone slave bundle (lane-positioned data)
//   dmem_req/cmd/width/addr/wdata : request side, data right-aligned
//   dmem_req_ack/rdata/resp       : responder side
module ycr_dmem_wb_initiator
  import ycr_dmem_wb_initiator_pkg::*;
#(
  parameter int unsigned RESP_TMO = 255,
  parameter int unsigned TMO_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ycr_dmem_wb_initiator_if.slave       wb,
  output logic                         dmem_req,
  output logic                         dmem_cmd,
  output logic [1:0]                   dmem_width,
  output logic [31:0]                  dmem_addr,
  output logic [31:0]                  dmem_wdata,
  input  logic                         dmem_req_ack,
  input  logic [31:0]                  dmem_rdata,
  input  logic [1:0]                   dmem_resp
);

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(RESP_TMO - 1);

  type_ycr_wbi_fsm_e   state_q, state_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                abort_q, abort_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  type_ycr_mem_cmd_e   cmd_q;
  type_ycr_mem_width_e width_q;
  logic [1:0]          lane_q;
  logic [3:0]          sel_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         dat_q;

  type_ycr_mem_width_e dec_width;
  logic [1:0]          dec_lane;
  logic                dec_illegal;
  logic                capture;
  logic                rd_capture;
  logic                tmo_hit;

  ycr_wbi_sel_decode u_sel_decode (
    .sel_i     (wb.wbd_sel_i),
    .width_o   (dec_width),
    .lane_o    (dec_lane),
    .illegal_o (dec_illegal)
  );

  assign tmo_hit = (RESP_TMO != 0) && (tmo_q == TmoLast);

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    abort_d    = abort_q;
    capture    = 1'b0;
    rd_capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wb.wbd_cyc_i && wb.wbd_stb_i) begin
          capture = 1'b1;
          abort_d = 1'b0;
          state_d = dec_illegal ? StErr : StReq;
        end
      end
      StReq: begin
        tmo_d = '0;
        if (dmem_req_ack) state_d = StResp;
      end
      StResp: begin
        // RDY_OK is checked first so it wins over a coincident timeout.
        if (dmem_resp == YCR_MEM_RESP_RDY_OK) begin
          state_d    = StAck;
          rd_capture = (cmd_q == YCR_MEM_CMD_RD);
        end else if (dmem_resp == YCR_MEM_RESP_RDY_ER || tmo_hit) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StAck:   state_d = StDone;
      StErr:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A master that abandons the cycle still lets the dmem transfer finish, but gets no reply.
    if (state_q != StIdle && !wb.wbd_cyc_i) abort_d = 1'b1;
    ack_d = (state_d == StAck) && !abort_d;
    err_d = (state_d == StErr) && !abort_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cmd_q   <= YCR_MEM_CMD_RD;
      width_q <= YCR_MEM_WIDTH_WORD;
      lane_q  <= 2'd0;
      sel_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (capture) begin
        cmd_q   <= wb.wbd_we_i ? YCR_MEM_CMD_WR : YCR_MEM_CMD_RD;
        width_q <= dec_width;
        lane_q  <= dec_lane;
        sel_q   <= wb.wbd_sel_i;
        addr_q  <= {wb.wbd_adr_i[31:2], dec_lane};
        wdata_q <= wb.wbd_dat_i >> {dec_lane, 3'b000};
      end
      if (rd_capture) begin
        dat_q <= (dmem_rdata << {lane_q, 3'b000}) & ycr_wbi_sel_mask(sel_q);
      end
    end
  end

  assign dmem_req   = (state_q == StReq);
  assign dmem_cmd   = cmd_q;
  assign dmem_width = width_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  assign wb.wbd_dat_o = dat_q;
  assign wb.wbd_ack_o = ack_q;
  assign wb.wbd_err_o = err_q;

endmodule

// File: tb/tb_ycr_dmem_wb_initiator.sv
// Bench for the Wishbone-to-dmem bridge with a small TCM-like responder model.
module tb_ycr_dmem_wb_initiator;

  localparam int unsigned RespTmo = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;

  ycr_dmem_wb_initiator_if wb_if ();

  ycr_dmem_wb_initiator #(
    .RESP_TMO (RespTmo),
    .TMO_W    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb           (wb_if),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp)
  );

  always #5 clk = ~clk;

  // Responder: 0 = answers RDY_OK, 1 = never answers, 2 = answers RDY_ER.
  int unsigned rsp_mode;
  int unsigned rsp_lat;
  logic [7:0]  mem [0:4095];
  logic        busy;
  int unsigned lat_cnt;
  logic        t_cmd;
  logic [1:0]  t_width;
  logic [11:0] t_a;
  logic [31:0] t_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req_ack <= 1'b0;
      dmem_resp    <= 2'b00;
      dmem_rdata   <= '0;
      busy         <= 1'b0;
      lat_cnt      <= 0;
    end else begin
      dmem_req_ack <= 1'b0;
      dmem_resp    <= 2'b00;
      if (dmem_req && !dmem_req_ack && !busy) dmem_req_ack <= 1'b1;
      if (dmem_req && dmem_req_ack) begin
        busy    <= 1'b1;
        lat_cnt <= rsp_lat;
        t_cmd   <= dmem_cmd;
        t_width <= dmem_width;
        t_a     <= dmem_addr[11:0];
        t_wdata <= dmem_wdata;
      end
      if (busy) begin
        if (lat_cnt == 0) begin
          if (rsp_mode == 0) begin
            dmem_resp <= 2'b01;
            busy      <= 1'b0;
            if (t_cmd) begin
              mem[t_a] <= t_wdata[7:0];
              if (t_width != 2'd0) mem[t_a + 12'd1] <= t_wdata[15:8];
              if (t_width == 2'd2) begin
                mem[t_a + 12'd2] <= t_wdata[23:16];
                mem[t_a + 12'd3] <= t_wdata[31:24];
              end
            end else begin
              case (t_width)
                2'd0:    dmem_rdata <= {24'd0, mem[t_a]};
                2'd1:    dmem_rdata <= {16'd0, mem[t_a + 12'd1], mem[t_a]};
                default: dmem_rdata <= {mem[t_a + 12'd3], mem[t_a + 12'd2],
                                        mem[t_a + 12'd1], mem[t_a]};
              endcase
            end
          end else if (rsp_mode == 2) begin
            dmem_resp <= 2'b10;
            busy      <= 1'b0;
          end
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  // Observers, sampled mid-cycle.
  int unsigned cyc_n = 0;
  int unsigned ack_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned req_cnt = 0;
  int unsigned both_cnt = 0;
  int unsigned ack_neg = 0;
  int unsigned err_neg = 0;

  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (wb_if.wbd_ack_o) ack_cnt <= ack_cnt + 1;
    if (wb_if.wbd_err_o) err_cnt <= err_cnt + 1;
    if (dmem_req) req_cnt <= req_cnt + 1;
    if (wb_if.wbd_ack_o && wb_if.wbd_err_o) both_cnt <= both_cnt + 1;
    if (dmem_req_ack) ack_neg <= cyc_n;
    if (wb_if.wbd_err_o) err_neg <= cyc_n;
  end

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    @(posedge clk); #1;
    wb_if.wbd_cyc_i = 1'b1;
    wb_if.wbd_stb_i = 1'b1;
    wb_if.wbd_we_i  = we;
    wb_if.wbd_adr_i = adr;
    wb_if.wbd_dat_i = dat;
    wb_if.wbd_sel_i = sel;
  endtask

  task automatic wb_stop();
    wb_if.wbd_cyc_i = 1'b0;
    wb_if.wbd_stb_i = 1'b0;
  endtask

  // Full transfer; reports ack/err/req-cycle counts over the transfer plus a short tail.
  task automatic wb_xfer(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         output logic [31:0] rdat, output int unsigned acks,
                         output int unsigned errs, output int unsigned reqs);
    int unsigned a0, e0, r0;
    logic done;
    a0 = ack_cnt; e0 = err_cnt; r0 = req_cnt;
    done = 1'b0;
    wb_start(we, adr, dat, sel);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (wb_if.wbd_ack_o || wb_if.wbd_err_o) done = 1'b1;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    wb_stop();
    repeat (3) @(negedge clk);
    #1;
    rdat = wb_if.wbd_dat_o;
    acks = ack_cnt - a0;
    errs = err_cnt - e0;
    reqs = req_cnt - r0;
  endtask

  task automatic wait_req_ack(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dmem_req_ack) seen = 1'b1;
    end
    check({tag, "_req_ack_seen"}, {31'd0, seen}, 32'd1);
  endtask

  logic [31:0] rd;
  int unsigned na, ne, nr;

  initial begin
    rst_n    = 1'b0;
    rsp_mode = 0;
    rsp_lat  = 1;
    wb_if.wbd_cyc_i = 1'b0;
    wb_if.wbd_stb_i = 1'b0;
    wb_if.wbd_we_i  = 1'b0;
    wb_if.wbd_adr_i = '0;
    wb_if.wbd_dat_i = '0;
    wb_if.wbd_sel_i = '0;
    repeat (3) @(negedge clk);
    check("rst_req",   {31'd0, dmem_req}, 32'd0);
    check("rst_cmd",   {31'd0, dmem_cmd}, 32'd0);
    check("rst_width", {30'd0, dmem_width}, 32'd2);
    check("rst_addr",  dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_ack",   {31'd0, wb_if.wbd_ack_o}, 32'd0);
    check("rst_err",   {31'd0, wb_if.wbd_err_o}, 32'd0);
    check("rst_dato",  wb_if.wbd_dat_o, 32'd0);
    rst_n = 1'b1;

    // Word write, then observe what the responder was handed.
    wb_xfer("w004", 1'b1, 32'h004, 32'hDEADBEEF, 4'b1111, rd, na, ne, nr);
    check("w004_acks",  na, 32'd1);
    check("w004_errs",  ne, 32'd0);
    check("w004_reqs",  nr, 32'd2);
    check("w004_cmd",   {31'd0, t_cmd}, 32'd1);
    check("w004_width", {30'd0, t_width}, 32'd2);
    check("w004_wdata", t_wdata, 32'hDEADBEEF);
    wb_xfer("r004", 1'b0, 32'h004, 32'd0, 4'b1111, rd, na, ne, nr);
    check("r004_data",  rd, 32'hDEADBEEF);
    check("r004_acks",  na, 32'd1);

    // Byte write into lane 2 of a pre-filled word.
    wb_xfer("w800", 1'b1, 32'h800, 32'hDEADBEEF, 4'b1111, rd, na, ne, nr);
    check("w800_acks", na, 32'd1);
    wb_xfer("w802", 1'b1, 32'h802, 32'h00AB0000, 4'b0100, rd, na, ne, nr);
    check("w802_width", {30'd0, t_width}, 32'd0);
    check("w802_addr",  {20'd0, t_a}, 32'h802);
    check("w802_wdata", {24'd0, t_wdata[7:0]}, 32'hAB);
    wb_xfer("r800", 1'b0, 32'h800, 32'd0, 4'b1111, rd, na, ne, nr);
    check("r800_data", rd, 32'hDEABBEEF);

    // Upper halfword and single-byte reads come back lane-positioned.
    wb_xfer("r006", 1'b0, 32'h006, 32'd0, 4'b1100, rd, na, ne, nr);
    check("r006_width", {30'd0, t_width}, 32'd1);
    check("r006_addr",  {20'd0, t_a}, 32'h006);
    check("r006_data",  rd, 32'hDEAD0000);
    wb_xfer("r005", 1'b0, 32'h004, 32'd0, 4'b0010, rd, na, ne, nr);
    check("r005_data",  rd, 32'h0000BE00);

    // Illegal select: error without touching dmem, dat_o left alone.
    wb_xfer("sel0101", 1'b0, 32'h100, 32'd0, 4'b0101, rd, na, ne, nr);
    check("sel0101_errs", ne, 32'd1);
    check("sel0101_acks", na, 32'd0);
    check("sel0101_reqs", nr, 32'd0);
    check("sel0101_dato", rd, 32'h0000BE00);

    // Silent responder: err_o rises on the RespTmo-th edge after the one that took req_ack.
    rsp_mode = 1;
    wb_xfer("tmo", 1'b0, 32'h004, 32'd0, 4'b1111, rd, na, ne, nr);
    check("tmo_errs",  ne, 32'd1);
    check("tmo_acks",  na, 32'd0);
    check("tmo_delay", err_neg - ack_neg, RespTmo + 1);
    rsp_mode = 0;
    repeat (4) @(negedge clk);
    wb_xfer("after_tmo", 1'b0, 32'h004, 32'd0, 4'b1111, rd, na, ne, nr);
    check("after_tmo_data", rd, 32'hDEADBEEF);

    rsp_mode = 2;
    wb_xfer("rdy_er", 1'b0, 32'h004, 32'd0, 4'b1111, rd, na, ne, nr);
    check("rdy_er_errs", ne, 32'd1);
    check("rdy_er_acks", na, 32'd0);
    rsp_mode = 0;

    // Master drops cyc mid-transfer: no ack, bridge still usable afterwards.
    rsp_lat = 4;
    na = ack_cnt; ne = err_cnt;
    wb_start(1'b0, 32'h004, 32'd0, 4'b1111);
    wait_req_ack("drop");
    #1;
    wb_stop();
    repeat (12) @(negedge clk);
    check("drop_acks", ack_cnt - na, 32'd0);
    check("drop_errs", err_cnt - ne, 32'd0);
    rsp_lat = 1;
    wb_xfer("after_drop", 1'b0, 32'h800, 32'd0, 4'b1111, rd, na, ne, nr);
    check("after_drop_data", rd, 32'hDEABBEEF);

    // Asynchronous reset while waiting in RESP.
    rsp_mode = 1;
    wb_start(1'b1, 32'h010, 32'h11112222, 4'b1111);
    wait_req_ack("rst");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req",   {31'd0, dmem_req}, 32'd0);
    check("rst_mid_ack",   {31'd0, wb_if.wbd_ack_o}, 32'd0);
    check("rst_mid_err",   {31'd0, wb_if.wbd_err_o}, 32'd0);
    check("rst_mid_width", {30'd0, dmem_width}, 32'd2);
    check("rst_mid_addr",  dmem_addr, 32'd0);
    wb_stop();
    rsp_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_xfer("w010", 1'b1, 32'h010, 32'h12345678, 4'b1111, rd, na, ne, nr);
    check("w010_acks", na, 32'd1);
    check("w010_reqs", nr, 32'd2);
    wb_xfer("r010", 1'b0, 32'h010, 32'd0, 4'b0011, rd, na, ne, nr);
    check("r010_data", rd, 32'h00005678);

    check("ack_err_overlap", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
